// File: rtl/demux_e_router.sv
// rtl/demux_e_router.sv - 1:2 stream router with per-channel holding registers and saturating drain counters
module demux_e_router #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             In_Valid,
  output logic             In_Ready,
  input  logic [WIDTH-1:0] In_Data,
  input  logic             In_Sel,
  output logic             Out_Valid0,
  input  logic             Out_Ready0,
  output logic [WIDTH-1:0] Out_Data0,
  output logic             Out_Valid1,
  input  logic             Out_Ready1,
  output logic [WIDTH-1:0] Out_Data1,
  output logic [CNT_W-1:0] Cnt0,
  output logic [CNT_W-1:0] Cnt1
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } chan_state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  chan_state_t state0, state1;
  chan_state_t state0_next, state1_next;
  logic        accept;
  logic        accept0, accept1;
  logic        drain0, drain1;

  assign Out_Valid0 = (state0 == FULL);
  assign Out_Valid1 = (state1 == FULL);

  // The producer may send whenever the addressed channel is empty or being
  // emptied this cycle; the other channel's state never blocks it.
  assign In_Ready = In_Sel ? (!Out_Valid1 || Out_Ready1)
                           : (!Out_Valid0 || Out_Ready0);

  assign accept  = In_Valid && In_Ready;
  assign accept0 = accept && !In_Sel;
  assign accept1 = accept &&  In_Sel;
  assign drain0  = Out_Valid0 && Out_Ready0;
  assign drain1  = Out_Valid1 && Out_Ready1;

  // Channel state registers; reset discards any held word
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state0 <= EMPTY;
      state1 <= EMPTY;
    end else begin
      state0 <= state0_next;
      state1 <= state1_next;
    end
  end

  // Next state: an accept refills the slot (even while draining), a drain alone empties it
  always_comb begin
    state0_next = state0;
    state1_next = state1;
    if (accept0) begin
      state0_next = FULL;
    end else if (drain0) begin
      state0_next = EMPTY;
    end
    if (accept1) begin
      state1_next = FULL;
    end else if (drain1) begin
      state1_next = EMPTY;
    end
  end

  // Holding registers load only on accept, so data stays stable while stalled
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      Out_Data0 <= '0;
      Out_Data1 <= '0;
    end else begin
      if (accept0) begin
        Out_Data0 <= In_Data;
      end
      if (accept1) begin
        Out_Data1 <= In_Data;
      end
    end
  end

  // Per-channel delivered-word counters, held at all-ones once saturated
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      Cnt0 <= '0;
      Cnt1 <= '0;
    end else begin
      if (drain0 && (Cnt0 != CNT_MAX)) begin
        Cnt0 <= Cnt0 + 1'b1;
      end
      if (drain1 && (Cnt1 != CNT_MAX)) begin
        Cnt1 <= Cnt1 + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_demux_e_router.sv
// tb/tb_demux_e_router.sv - scoreboard bench for demux_e_router
module tb_demux_e_router;

  localparam int W = 32;

  logic         Clk;
  logic         Rst_n;
  logic         In_Valid;
  logic         In_Sel;
  logic [W-1:0] In_Data;
  logic         Out_Ready0;
  logic         Out_Ready1;

  logic         a_ready, a_valid0, a_valid1;
  logic [W-1:0] a_data0, a_data1;
  logic [15:0]  a_cnt0, a_cnt1;

  logic         b_ready, b_valid0, b_valid1;
  logic [W-1:0] b_data0, b_data1;
  logic [3:0]   b_cnt0, b_cnt1;

  int n_cmp;
  int n_bad;

  logic [W-1:0] q0[$];
  logic [W-1:0] q1[$];
  int           exp_cnt0, exp_cnt1;
  logic         m_full0, m_full1, m_ready;

  demux_e_router #(.WIDTH(W), .CNT_W(16)) dut (
    .Clk(Clk), .Rst_n(Rst_n),
    .In_Valid(In_Valid), .In_Ready(a_ready), .In_Data(In_Data), .In_Sel(In_Sel),
    .Out_Valid0(a_valid0), .Out_Ready0(Out_Ready0), .Out_Data0(a_data0),
    .Out_Valid1(a_valid1), .Out_Ready1(Out_Ready1), .Out_Data1(a_data1),
    .Cnt0(a_cnt0), .Cnt1(a_cnt1)
  );

  demux_e_router #(.WIDTH(W), .CNT_W(4)) dut_small (
    .Clk(Clk), .Rst_n(Rst_n),
    .In_Valid(In_Valid), .In_Ready(b_ready), .In_Data(In_Data), .In_Sel(In_Sel),
    .Out_Valid0(b_valid0), .Out_Ready0(Out_Ready0), .Out_Data0(b_data0),
    .Out_Valid1(b_valid1), .Out_Ready1(Out_Ready1), .Out_Data1(b_data1),
    .Cnt0(b_cnt0), .Cnt1(b_cnt1)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  function automatic int sat(input int c, input int m);
    return (c > m) ? m : c;
  endfunction

  // Scoreboard monitor, sampled on the falling edge between active edges
  always @(negedge Clk) begin
    if (!Rst_n) begin
      q0.delete();
      q1.delete();
      exp_cnt0 = 0;
      exp_cnt1 = 0;
    end else begin
      m_full0 = (q0.size() != 0);
      m_full1 = (q1.size() != 0);
      n_cmp++;
      if (a_valid0 !== m_full0 || b_valid0 !== m_full0) begin
        n_bad++;
        $display("FAIL sb_valid0 t=%0t got %b/%b want %b", $time, a_valid0, b_valid0, m_full0);
      end
      n_cmp++;
      if (a_valid1 !== m_full1 || b_valid1 !== m_full1) begin
        n_bad++;
        $display("FAIL sb_valid1 t=%0t got %b/%b want %b", $time, a_valid1, b_valid1, m_full1);
      end
      m_ready = In_Sel ? (!m_full1 || Out_Ready1) : (!m_full0 || Out_Ready0);
      n_cmp++;
      if (a_ready !== m_ready || b_ready !== m_ready) begin
        n_bad++;
        $display("FAIL sb_in_ready t=%0t got %b/%b want %b", $time, a_ready, b_ready, m_ready);
      end
      n_cmp++;
      if (a_cnt0 !== 16'(sat(exp_cnt0, 65535)) || b_cnt0 !== 4'(sat(exp_cnt0, 15))) begin
        n_bad++;
        $display("FAIL sb_cnt0 t=%0t got %0d/%0d want %0d", $time, a_cnt0, b_cnt0, exp_cnt0);
      end
      n_cmp++;
      if (a_cnt1 !== 16'(sat(exp_cnt1, 65535)) || b_cnt1 !== 4'(sat(exp_cnt1, 15))) begin
        n_bad++;
        $display("FAIL sb_cnt1 t=%0t got %0d/%0d want %0d", $time, a_cnt1, b_cnt1, exp_cnt1);
      end
      if (m_full0) begin
        n_cmp++;
        if (a_data0 !== q0[0] || b_data0 !== q0[0]) begin
          n_bad++;
          $display("FAIL sb_data0 t=%0t got %h/%h want %h", $time, a_data0, b_data0, q0[0]);
        end
        if (Out_Ready0) begin
          void'(q0.pop_front());
          exp_cnt0++;
        end
      end
      if (m_full1) begin
        n_cmp++;
        if (a_data1 !== q1[0] || b_data1 !== q1[0]) begin
          n_bad++;
          $display("FAIL sb_data1 t=%0t got %h/%h want %h", $time, a_data1, b_data1, q1[0]);
        end
        if (Out_Ready1) begin
          void'(q1.pop_front());
          exp_cnt1++;
        end
      end
      if (In_Valid && m_ready) begin
        if (In_Sel) q1.push_back(In_Data);
        else        q0.push_back(In_Data);
      end
    end
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic send(input logic sel, input logic [W-1:0] d);
    In_Valid = 1'b1;
    In_Sel   = sel;
    In_Data  = d;
  endtask

  task automatic idle();
    In_Valid = 1'b0;
    In_Sel   = 1'b0;
    In_Data  = '0;
  endtask

  task automatic do_reset();
    idle();
    Rst_n = 1'b0;
    @(negedge Clk);
    @(negedge Clk);
    #2 Rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    n_cmp++;
    if (a_valid0 !== 1'b0 || a_valid1 !== 1'b0 || a_cnt0 !== 16'd0 || a_data0 !== '0) begin
      n_bad++;
      $display("FAIL reset_init got v0=%b v1=%b c0=%0d d0=%h want 0", a_valid0, a_valid1, a_cnt0, a_data0);
    end
    Out_Ready0 = 1'b1;
    Out_Ready1 = 1'b0;
    send(1'b0, 32'h11);
    tick();
    send(1'b1, 32'h22);
    tick();
    Out_Ready0 = 1'b0;
    send(1'b0, 32'h33);
    tick();
    idle();
    n_cmp++;
    if (a_valid0 !== 1'b1 || a_valid1 !== 1'b1 || a_cnt0 !== 16'd1) begin
      n_bad++;
      $display("FAIL reset_preload got v0=%b v1=%b c0=%0d want 1 1 1", a_valid0, a_valid1, a_cnt0);
    end
    #1 Rst_n = 1'b0;
    #1;
    n_cmp++;
    if (a_valid0 !== 1'b0 || a_valid1 !== 1'b0 || a_data0 !== '0 || a_data1 !== '0 ||
        a_cnt0 !== 16'd0 || a_cnt1 !== 16'd0 || b_valid0 !== 1'b0 || b_cnt0 !== 4'd0) begin
      n_bad++;
      $display("FAIL reset_async got v=%b%b d0=%h d1=%h c0=%0d c1=%0d want all zero",
               a_valid0, a_valid1, a_data0, a_data1, a_cnt0, a_cnt1);
    end
    @(negedge Clk);
    #2 Rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic_route();
    Out_Ready0 = 1'b1;
    Out_Ready1 = 1'b1;
    send(1'b0, 32'h80);
    tick();
    n_cmp++;
    if (a_valid0 !== 1'b1 || a_data0 !== 32'h80) begin
      n_bad++;
      $display("FAIL basic_ch0 got v=%b d=%h want 1 00000080", a_valid0, a_data0);
    end
    send(1'b1, 32'h8000);
    tick();
    idle();
    n_cmp++;
    if (a_valid1 !== 1'b1 || a_data1 !== 32'h8000 || a_valid0 !== 1'b0) begin
      n_bad++;
      $display("FAIL basic_ch1 got v1=%b d1=%h v0=%b want 1 00008000 0", a_valid1, a_data1, a_valid0);
    end
    tick();
    n_cmp++;
    if (a_cnt0 !== 16'd1 || a_cnt1 !== 16'd1) begin
      n_bad++;
      $display("FAIL basic_cnt got %0d %0d want 1 1", a_cnt0, a_cnt1);
    end
  endtask

  task automatic test_stall();
    Out_Ready0 = 1'b0;
    send(1'b0, 32'hA0A0);
    tick();
    send(1'b0, 32'hB1B1);
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (a_ready !== 1'b0 || a_data0 !== 32'hA0A0) begin
        n_bad++;
        $display("FAIL stall_hold cyc=%0d got rdy=%b d0=%h want 0 0000a0a0", i, a_ready, a_data0);
      end
      tick();
    end
    Out_Ready0 = 1'b1;
    #1;
    n_cmp++;
    if (a_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL stall_release got rdy=%b want 1", a_ready);
    end
    tick();
    idle();
    n_cmp++;
    if (a_valid0 !== 1'b1 || a_data0 !== 32'hB1B1) begin
      n_bad++;
      $display("FAIL stall_second got v=%b d=%h want 1 0000b1b1", a_valid0, a_data0);
    end
    tick();
  endtask

  task automatic test_independent();
    Out_Ready0 = 1'b0;
    Out_Ready1 = 1'b1;
    send(1'b0, 32'hC0C0);
    tick();
    send(1'b1, 32'hD1D1);
    #1;
    n_cmp++;
    if (a_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL indep_ready got %b want 1", a_ready);
    end
    tick();
    idle();
    n_cmp++;
    if (a_valid1 !== 1'b1 || a_data1 !== 32'hD1D1 || a_valid0 !== 1'b1 || a_data0 !== 32'hC0C0) begin
      n_bad++;
      $display("FAIL indep_data got v1=%b d1=%h v0=%b d0=%h want 1 0000d1d1 1 0000c0c0",
               a_valid1, a_data1, a_valid0, a_data0);
    end
    tick();
    Out_Ready0 = 1'b1;
    tick();
    tick();
  endtask

  task automatic test_back_to_back();
    do_reset();
    Out_Ready0 = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      send(1'b0, W'(i));
      tick();
      n_cmp++;
      if (a_valid0 !== 1'b1 || a_data0 !== W'(i)) begin
        n_bad++;
        $display("FAIL b2b_word%0d got v=%b d=%h want 1 %h", i, a_valid0, a_data0, W'(i));
      end
    end
    idle();
    tick();
    n_cmp++;
    if (a_cnt0 !== 16'd8 || a_valid0 !== 1'b0) begin
      n_bad++;
      $display("FAIL b2b_cnt got c0=%0d v0=%b want 8 0", a_cnt0, a_valid0);
    end
  endtask

  task automatic test_saturation();
    do_reset();
    Out_Ready1 = 1'b1;
    for (int i = 0; i < 20; i++) begin
      send(1'b1, 32'h100 + W'(i));
      tick();
    end
    idle();
    tick();
    n_cmp++;
    if (b_cnt1 !== 4'd15 || a_cnt1 !== 16'd20) begin
      n_bad++;
      $display("FAIL sat_cnt got small=%0d wide=%0d want 15 20", b_cnt1, a_cnt1);
    end
    Out_Ready1 = 1'b0;
    send(1'b1, 32'hDEAD);
    tick();
    idle();
    #1 Rst_n = 1'b0;
    #1;
    n_cmp++;
    if (b_valid1 !== 1'b0 || b_cnt1 !== 4'd0 || a_valid1 !== 1'b0) begin
      n_bad++;
      $display("FAIL sat_reset got v1=%b c1=%0d want 0 0", b_valid1, b_cnt1);
    end
    @(negedge Clk);
    #2 Rst_n = 1'b1;
    tick();
    Out_Ready1 = 1'b1;
    send(1'b1, 32'hBEEF);
    tick();
    idle();
    n_cmp++;
    if (b_valid1 !== 1'b1 || b_data1 !== 32'hBEEF) begin
      n_bad++;
      $display("FAIL sat_after got v1=%b d1=%h want 1 0000beef", b_valid1, b_data1);
    end
    tick();
    n_cmp++;
    if (b_cnt1 !== 4'd1) begin
      n_bad++;
      $display("FAIL sat_after_cnt got %0d want 1", b_cnt1);
    end
  endtask

  initial begin
    n_cmp      = 0;
    n_bad      = 0;
    exp_cnt0   = 0;
    exp_cnt1   = 0;
    Rst_n      = 1'b0;
    Out_Ready0 = 1'b0;
    Out_Ready1 = 1'b0;
    idle();
    repeat (2) @(negedge Clk);
    #2 Rst_n = 1'b1;
    tick();
    test_reset();
    test_basic_route();
    test_stall();
    test_independent();
    test_back_to_back();
    test_saturation();
    repeat (2) tick();
    n_cmp++;
    if (q0.size() != 0 || q1.size() != 0) begin
      n_bad++;
      $display("FAIL drain_end got q0=%0d q1=%0d want 0 0", q0.size(), q1.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1);
  end

endmodule
